rpn_tokenizer: RTL and testbench

- Upstream stage of op_controller. Converts the byte stream from the UART receiver into RPN tokens.
- Decimal digit runs become number pushes for the operand stack.
- Operator characters become an is_op strobe plus a held op code and arg_cnt.
- Separators end a number. Malformed input is discarded and flagged on err.

---
 rtl/rpn_tokenizer_if.sv | 24 ++
 rtl/rpn_tokenizer.sv | 169 ++++++++++++++++
 tb/tb_rpn_tokenizer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_tokenizer_if.sv
// Byte-in / token-out bundle between the UART receiver, rpn_tokenizer and op_controller.
interface rpn_tokenizer_if #(
    parameter int unsigned WIDTH = 16
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             num_valid;
    logic [WIDTH-1:0] num_value;
    logic             is_op;
    logic [3:0]       op;
    logic [1:0]       arg_cnt;
    logic             err;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, num_valid, num_value, is_op, op, arg_cnt, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, num_valid, num_value, is_op, op, arg_cnt, err
    );
endinterface

// File: rtl/rpn_tokenizer.sv
// Turns an ASCII byte stream into RPN tokens: unsigned number pushes and operator strobes.
// An operator that terminates a number is deferred one cycle so num_valid and is_op never coincide.
module rpn_tokenizer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    rpn_tokenizer_if.slave bus
);
    localparam int unsigned AW = WIDTH + 4;

    typedef enum logic [1:0] {IDLE, NUM, EMIT_OP} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic             ovf, ovf_nx;
    logic [3:0]       pend_op, pend_op_nx;
    logic [1:0]       pend_cnt, pend_cnt_nx;

    logic             rdy_q, rdy_nx;
    logic             nv_q, nv_nx;
    logic [WIDTH-1:0] val_q, val_nx;
    logic             iop_q, iop_nx;
    logic [3:0]       op_q, op_nx;
    logic [1:0]       cnt_q, cnt_nx;
    logic             err_q, err_nx;

    logic             is_digit, is_sep, is_opch;
    logic [3:0]       digit, code;
    logic [1:0]       cnt;
    logic [AW-1:0]    prod;

    // Character classification and operator decode
    always_comb begin
        is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        digit    = 4'(bus.rx_data - 8'h30);
        is_sep   = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
        is_opch  = 1'b1;
        code     = 4'h0;
        cnt      = 2'd2;
        case (bus.rx_data)
            8'h2B:   code = 4'h0;
            8'h2D:   code = 4'h1;
            8'h2A:   code = 4'h2;
            8'h2F:   code = 4'h3;
            8'h2E: begin
                code = 4'h4;
                cnt  = 2'd1;
            end
            default: begin
                is_opch = 1'b0;
                code    = 4'hf;
                cnt     = 2'd0;
            end
        endcase
        // Wide enough that acc*10+9 never wraps; the top bits flag overflow
        prod = AW'(acc) * AW'(10) + AW'(digit);
    end

    // Next-state and output logic
    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        ovf_nx      = ovf;
        pend_op_nx  = pend_op;
        pend_cnt_nx = pend_cnt;
        nv_nx       = 1'b0;
        val_nx      = val_q;
        iop_nx      = 1'b0;
        op_nx       = op_q;
        cnt_nx      = cnt_q;
        err_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (is_digit) begin
                        acc_nx   = WIDTH'(digit);
                        ovf_nx   = 1'b0;
                        state_nx = NUM;
                    end else if (is_opch) begin
                        iop_nx = 1'b1;
                        op_nx  = code;
                        cnt_nx = cnt;
                    end else if (!is_sep) begin
                        err_nx = 1'b1;
                        op_nx  = 4'hf;
                        cnt_nx = 2'd0;
                    end
                end
            end
            NUM: begin
                if (bus.rx_valid) begin
                    if (is_digit) begin
                        acc_nx = prod[WIDTH-1:0];
                        ovf_nx = ovf | (|prod[AW-1:WIDTH]);
                    end else begin
                        if (is_sep || is_opch) begin
                            if (ovf) begin
                                err_nx = 1'b1;
                            end else begin
                                nv_nx  = 1'b1;
                                val_nx = acc;
                            end
                        end else begin
                            err_nx = 1'b1;
                        end
                        if (is_opch) begin
                            pend_op_nx  = code;
                            pend_cnt_nx = cnt;
                            state_nx    = EMIT_OP;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            EMIT_OP: begin
                // Any byte arriving here is dropped
                iop_nx   = 1'b1;
                op_nx    = pend_op;
                cnt_nx   = pend_cnt;
                err_nx   = bus.rx_valid;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        rdy_nx = (state_nx != EMIT_OP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            ovf      <= 1'b0;
            pend_op  <= 4'hf;
            pend_cnt <= 2'd0;
            rdy_q    <= 1'b1;
            nv_q     <= 1'b0;
            val_q    <= '0;
            iop_q    <= 1'b0;
            op_q     <= 4'hf;
            cnt_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            ovf      <= ovf_nx;
            pend_op  <= pend_op_nx;
            pend_cnt <= pend_cnt_nx;
            rdy_q    <= rdy_nx;
            nv_q     <= nv_nx;
            val_q    <= val_nx;
            iop_q    <= iop_nx;
            op_q     <= op_nx;
            cnt_q    <= cnt_nx;
            err_q    <= err_nx;
        end
    end

    assign bus.rx_ready  = rdy_q;
    assign bus.num_valid = nv_q;
    assign bus.num_value = val_q;
    assign bus.is_op     = iop_q;
    assign bus.op        = op_q;
    assign bus.arg_cnt   = cnt_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_rpn_tokenizer.sv
// Scoreboard bench for rpn_tokenizer: a string-level tokenizer model predicts cycle-stamped
// token events, and an independent monitor compares them against the DUT every cycle.
module tb_rpn_tokenizer;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rpn_tokenizer_if #(.WIDTH(WIDTH)) bus ();
    rpn_tokenizer #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int               cyc;
        logic             nv;
        logic [WIDTH-1:0] val;
        logic             iop;
        logic [3:0]       op;
        logic [1:0]       cnt;
        logic             er;
        logic             rdy;
    } ev_t;

    ev_t sbq[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: what has been seen so far, in text terms
    bit               m_in_num;
    bit               m_ovf;
    longint           m_val;
    int               m_pend;
    logic [WIDTH-1:0] m_num;
    logic [3:0]       m_op;
    logic [1:0]       m_cnt;
    string            ops = "+-*/.";

    function automatic void model_reset();
        m_in_num = 0;
        m_ovf    = 0;
        m_val    = 0;
        m_pend   = -10;
        m_num    = '0;
        m_op     = 4'hf;
        m_cnt    = 2'd0;
    endfunction

    // Merge into an event already scheduled for the same cycle, else append one
    function automatic void add_ev(int c, bit nv, bit iop, bit er, bit rdy);
        ev_t e;
        if (sbq.size() > 0 && sbq[$].cyc == c) begin
            e = sbq.pop_back();
        end else begin
            e.cyc = c; e.nv = 0; e.iop = 0; e.er = 0; e.rdy = 1;
        end
        e.nv  = e.nv | nv;
        e.iop = e.iop | iop;
        e.er  = e.er | er;
        e.rdy = e.rdy & rdy;
        e.val = m_num;
        e.op  = m_op;
        e.cnt = m_cnt;
        sbq.push_back(e);
    endfunction

    function automatic void model(int a, logic [7:0] b);
        int code = -1;
        bit dig  = (b >= 8'h30) && (b <= 8'h39);
        bit sep  = (b == 8'h20) || (b == 8'h0D) || (b == 8'h0A);
        for (int i = 0; i < 5; i++) if (b == ops[i]) code = i;
        if (a == m_pend) begin
            add_ev(a + 1, 0, 0, 1, 1);
            return;
        end
        if (!m_in_num) begin
            if (dig) begin
                m_in_num = 1;
                m_ovf    = 0;
                m_val    = longint'(int'(b) - 48);
            end else if (code >= 0) begin
                m_op  = 4'(code);
                m_cnt = (code == 4) ? 2'd1 : 2'd2;
                add_ev(a + 1, 0, 1, 0, 1);
            end else if (!sep) begin
                m_op  = 4'hf;
                m_cnt = 2'd0;
                add_ev(a + 1, 0, 0, 1, 1);
            end
        end else if (dig) begin
            m_val = m_val * 10 + longint'(int'(b) - 48);
            if (m_val >= (longint'(1) << WIDTH)) m_ovf = 1;
            m_val = m_val % (longint'(1) << WIDTH);
        end else begin
            m_in_num = 0;
            if (sep || code >= 0) begin
                if (!m_ovf) begin
                    m_num = WIDTH'(m_val);
                    add_ev(a + 1, 1, 0, 0, code < 0);
                end else begin
                    add_ev(a + 1, 0, 0, 1, code < 0);
                end
                if (code >= 0) begin
                    m_op   = 4'(code);
                    m_cnt  = (code == 4) ? 2'd1 : 2'd2;
                    m_pend = a + 1;
                    add_ev(a + 2, 0, 1, 0, 1);
                end
            end else begin
                add_ev(a + 1, 0, 0, 1, 1);
            end
        end
    endfunction

    // Monitor: every cycle either matches the next scheduled event or is quiet
    ev_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                mon_e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d: expected event never matched", mon_e.cyc);
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                mon_e = sbq.pop_front();
                checks++;
                if (bus.num_valid !== mon_e.nv || bus.num_value !== mon_e.val ||
                    bus.is_op !== mon_e.iop || bus.op !== mon_e.op ||
                    bus.arg_cnt !== mon_e.cnt || bus.err !== mon_e.er ||
                    bus.rx_ready !== mon_e.rdy) begin
                    errors++;
                    $display("FAIL event cyc=%0d got nv=%0b val=%0d iop=%0b op=%0h cnt=%0d err=%0b rdy=%0b want nv=%0b val=%0d iop=%0b op=%0h cnt=%0d err=%0b rdy=%0b",
                             cyc, bus.num_valid, bus.num_value, bus.is_op, bus.op, bus.arg_cnt,
                             bus.err, bus.rx_ready, mon_e.nv, mon_e.val, mon_e.iop, mon_e.op,
                             mon_e.cnt, mon_e.er, mon_e.rdy);
                end
            end else if (bus.num_valid || bus.is_op || bus.err || !bus.rx_ready) begin
                checks++;
                errors++;
                $display("FAIL unexpected cyc=%0d got nv=%0b iop=%0b err=%0b rdy=%0b want quiet cycle",
                         cyc, bus.num_valid, bus.is_op, bus.err, bus.rx_ready);
            end
        end
    end

    task automatic check_reset(input string name);
        checks++;
        if (bus.num_valid !== 1'b0 || bus.is_op !== 1'b0 || bus.err !== 1'b0 ||
            bus.rx_ready !== 1'b1 || bus.op !== 4'hf || bus.arg_cnt !== 2'd0 ||
            bus.num_value !== '0) begin
            errors++;
            $display("FAIL %s got nv=%0b iop=%0b err=%0b rdy=%0b op=%0h cnt=%0d val=%0d want 0 0 0 1 f 0 0",
                     name, bus.num_valid, bus.is_op, bus.err, bus.rx_ready, bus.op,
                     bus.arg_cnt, bus.num_value);
        end
    endtask

    // Driver sits on a falling edge; each byte is a single-cycle strobe
    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        model(cyc, b);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            idle(gap);
        end
    endtask

    task automatic async_reset(input string name);
        #2 rst = 1'b1;
        #1 check_reset(name);
        model_reset();
        sbq.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         k;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        #1 rst = 1'b1;
        #2 check_reset("reset_state");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        send_str("12 ", 0);          idle(2);
        send_str("3+", 0);           idle(3);
        send_str("3+7 ", 0);         idle(2);
        send_str(" - * / .", 1);     idle(2);
        send_str("65536 ", 0);       idle(1);
        send_str("65535 ", 0);       idle(1);
        send_str("4a5 ", 0);         idle(1);
        send_str("99999999+", 0);    idle(3);
        send_str("007\n8*9\r", 0);   idle(2);
        send_str("98", 0);           idle(1);
        async_reset("mid_number_reset");
        send_str(" ", 0);            idle(3);

        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 15);
            if (k < 8)       b = 8'(8'h30 + $urandom_range(0, 9));
            else if (k < 10) b = (k == 8) ? 8'h20 : 8'h0A;
            else if (k < 14) b = ops[$urandom_range(0, 4)];
            else             b = 8'($urandom_range(0, 255));
            send_byte(b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        send_str(" ", 0);
        idle(6);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending events want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
